// File: rtl/calc_sequencer_if.sv
// calc_sequencer_if: program-load, control and ALU bus of the calculator sequencer.
interface calc_sequencer_if #(parameter int ADDR_W = 4);
   logic              prog_we;
   logic [ADDR_W-1:0] prog_addr;
   logic [12:0]       prog_data;
   logic              start;
   logic [7:0]        alu_a;
   logic [7:0]        alu_b;
   logic [3:0]        alu_sel;
   logic [7:0]        alu_result;
   logic              alu_cout;
   logic [7:0]        acc;
   logic              carry;
   logic [ADDR_W-1:0] pc;
   logic              busy;
   logic              done;
   modport master (
      input  prog_we, prog_addr, prog_data, start, alu_result, alu_cout,
      output alu_a, alu_b, alu_sel, acc, carry, pc, busy, done
   );
   modport slave (
      output prog_we, prog_addr, prog_data, start, alu_result, alu_cout,
      input  alu_a, alu_b, alu_sel, acc, carry, pc, busy, done
   );
endinterface

// File: rtl/calc_sequencer.sv
// calc_sequencer: runs a small stored program through the external 8-bit ALU,
// two cycles per instruction (fetch, then execute and capture result/carry).
module calc_sequencer #(
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 2**ADDR_W
) (
   input logic              clk,
   input logic              rst,
   calc_sequencer_if.master bus
);
   typedef enum logic [1:0] {IDLE, FETCH, EXEC, DONE} state_t;
   state_t            state, next;
   logic [12:0]       mem [DEPTH];
   logic [12:0]       ir;
   logic [7:0]        acc;
   logic              carry;
   logic [ADDR_W-1:0] pc;
   logic              busy;
   logic              stop;
   assign stop = ir[12] || pc == ADDR_W'(DEPTH - 1);
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= next;
   always_comb
      next = state == IDLE  ? (bus.start ? FETCH : IDLE) :
             state == FETCH ? EXEC :
             state == EXEC  ? (stop ? DONE : FETCH) : IDLE;
   always_comb begin
      busy        = state == FETCH || state == EXEC;
      bus.busy    = busy;
      bus.done    = state == DONE;
      bus.alu_a   = acc;
      bus.alu_b   = state == EXEC ? ir[7:0] : 8'd0;
      bus.alu_sel = state == EXEC ? ir[11:8] : 4'b0010;
      bus.acc     = acc;
      bus.carry   = carry;
      bus.pc      = pc;
   end
   // program memory has no reset; writes are only honoured while not running
   always_ff @(posedge clk)
      if (bus.prog_we && !busy) mem[bus.prog_addr] <= bus.prog_data;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         acc   <= '0;
         carry <= 1'b0;
         pc    <= '0;
         ir    <= '0;
      end else if (state == IDLE && bus.start) begin
         acc   <= '0;
         carry <= 1'b0;
         pc    <= '0;
      end else if (state == FETCH) begin
         ir    <= mem[pc];
      end else if (state == EXEC) begin
         acc   <= bus.alu_result;
         carry <= bus.alu_cout;
         if (!stop) pc <= pc + 1'b1;
      end
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed program runs against a behavioural ALU, with a
// scoreboard of expected final acc/carry/pc/timing per run.
module tb_calc_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;
   typedef struct {
      logic [7:0] acc;
      logic       carry;
      logic [3:0] pc;
      int         edges;
   } exp_t;
   exp_t sb[$];
   calc_sequencer_if #(.ADDR_W(4)) bus();
   calc_sequencer #(.ADDR_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   // ALU: 0000 add, 0011 or, 1101 increment, anything else passes A; carry is always A+B
   logic [8:0] sum;
   always_comb begin
      sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      bus.alu_cout = sum[8];
      bus.alu_result = bus.alu_sel == 4'b0000 ? sum[7:0] :
                       bus.alu_sel == 4'b0011 ? (bus.alu_a | bus.alu_b) :
                       bus.alu_sel == 4'b1101 ? bus.alu_a + 8'd1 : bus.alu_a;
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic wr(input logic [3:0] a, input logic [12:0] d);
      bus.prog_we = 1'b1;
      bus.prog_addr = a;
      bus.prog_data = d;
      @(posedge clk);
      #1 bus.prog_we = 1'b0;
   endtask
   task automatic run(input logic [7:0] a, input logic c, input logic [3:0] p, input int n, input bit disturb);
      exp_t e;
      int edges = 0;
      int busy_cnt = 0;
      bit seen = 0;
      sb.push_back('{a, c, p, n});
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      bus.prog_we = 1'b0;
      if (bus.busy) busy_cnt++;
      while (!seen && edges < 100) begin
         @(posedge clk);
         #1 edges++;
         if (disturb && edges == 2) begin
            bus.start = 1'b1;
            bus.prog_we = 1'b1;
            bus.prog_addr = 4'd1;
            bus.prog_data = 13'h0077;
         end
         if (disturb && edges == 4) begin
            bus.start = 1'b0;
            bus.prog_we = 1'b0;
         end
         if (bus.busy) busy_cnt++;
         seen = bus.done;
      end
      chk("done_seen", 32'(seen), 32'd1);
      e = sb.pop_front();
      chk("done_edge", edges, e.edges);
      chk("busy_cycles", busy_cnt, e.edges);
      chk("acc", 32'(bus.acc), 32'(e.acc));
      chk("carry", 32'(bus.carry), 32'(e.carry));
      chk("pc", 32'(bus.pc), 32'(e.pc));
      @(posedge clk);
      #1 chk("done_pulse_len", 32'(bus.done), 32'd0);
      chk("idle_busy", 32'(bus.busy), 32'd0);
      chk("acc_hold", 32'(bus.acc), 32'(e.acc));
   endtask
   initial begin
      int seen;
      bus.prog_we = 1'b0;
      bus.prog_addr = '0;
      bus.prog_data = '0;
      bus.start = 1'b0;
      repeat (2) @(posedge clk);
      #1 chk("rst_acc", 32'(bus.acc), 32'd0);
      chk("rst_carry", 32'(bus.carry), 32'd0);
      chk("rst_pc", 32'(bus.pc), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_alu_sel", 32'(bus.alu_sel), 32'h2);
      rst = 1'b0;
      // basic run
      wr(4'd0, 13'h0305);
      wr(4'd1, 13'h0003);
      wr(4'd2, 13'h1010);
      run(8'h18, 1'b0, 4'd2, 6, 0);
      // carry capture
      wr(4'd0, 13'h03F0);
      wr(4'd1, 13'h1020);
      run(8'h10, 1'b1, 4'd1, 4, 0);
      wr(4'd1, 13'h100F);
      run(8'hFF, 1'b0, 4'd1, 4, 0);
      // full depth with no halt
      for (int i = 0; i < 16; i++) wr(4'(i), 13'h0D00);
      run(8'h10, 1'b0, 4'd15, 32, 0);
      // busy lockout: start and writes during the run are ignored
      wr(4'd0, 13'h0305);
      wr(4'd1, 13'h0003);
      wr(4'd2, 13'h1010);
      run(8'h18, 1'b0, 4'd2, 6, 1);
      run(8'h18, 1'b0, 4'd2, 6, 0);
      // reset mid-run
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk("pre_rst_acc", 32'(bus.acc), 32'h05);
      rst = 1'b1;
      #1 chk("mid_rst_acc", 32'(bus.acc), 32'd0);
      chk("mid_rst_carry", 32'(bus.carry), 32'd0);
      chk("mid_rst_pc", 32'(bus.pc), 32'd0);
      chk("mid_rst_busy", 32'(bus.busy), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1 seen += int'(bus.done) + int'(bus.busy);
      end
      chk("no_done_after_rst", seen, 0);
      run(8'h18, 1'b0, 4'd2, 6, 0);
      // write to address 0 in the same cycle as start
      wr(4'd1, 13'h1001);
      bus.prog_we = 1'b1;
      bus.prog_addr = 4'd0;
      bus.prog_data = 13'h0340;
      run(8'h41, 1'b0, 4'd1, 4, 0);
      chk("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
